// File: rtl/lift_ctrl_if.sv
// rtl/lift_ctrl_if.sv - slowref/request inputs and floor/door/motion indicators of the lift car controller
//
// Signals:
//   slowref     - one-clk step enable from the slow-reference generator
//   req         - floor request buttons, one bit per floor
//   floor       - current car floor
//   door_open   - car is in the door-open state
//   moving_up   - car is travelling up
//   moving_down - car is travelling down
//   pending     - latched outstanding requests
// Modports: master drives slowref/req and observes the indicators; slave is the controller side.
interface lift_ctrl_if #(
    parameter int N_FLOORS = 4,
    parameter int FLOOR_W  = 2
);
    logic                slowref;
    logic [N_FLOORS-1:0] req;
    logic [FLOOR_W-1:0]  floor;
    logic                door_open;
    logic                moving_up;
    logic                moving_down;
    logic [N_FLOORS-1:0] pending;

    modport master (
        output slowref, req,
        input  floor, door_open, moving_up, moving_down, pending
    );

    modport slave (
        input  slowref, req,
        output floor, door_open, moving_up, moving_down, pending
    );
endinterface

// File: rtl/lift_ctrl.sv
// rtl/lift_ctrl.sv - SCAN lift car controller stepped by the slowref enable pulse
//
// Ports:
//   clk   - system clock
//   reset - asynchronous active-high reset
//   bus   - lift_ctrl_if.slave: slowref, req in; floor, door_open, moving_up, moving_down, pending out
//
// Requests are captured every clk; movement and door timing advance only on slowref.
// All indicators come straight from registers.
module lift_ctrl #(
    parameter int N_FLOORS   = 4,
    parameter int FLOOR_W    = 2,
    parameter int DOOR_TICKS = 3
) (
    input  logic         clk,
    input  logic         reset,
    lift_ctrl_if.slave   bus
);
    localparam int TIMER_W = 4;
    localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(DOOR_TICKS - 1);
    localparam logic [FLOOR_W-1:0] TOP_FLOOR  = FLOOR_W'(N_FLOORS - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2,
        DOOR_OPEN = 2'd3
    } state_t;

    state_t              r_state,   w_state_nxt;
    logic [FLOOR_W-1:0]  r_floor,   w_floor_nxt;
    logic [N_FLOORS-1:0] r_pending, w_pending_nxt;
    logic                r_dir_up,  w_dir_up_nxt;
    logic [TIMER_W-1:0]  r_timer,   w_timer_nxt;

    logic [FLOOR_W-1:0]  w_floor_up;
    logic [FLOOR_W-1:0]  w_floor_dn;
    logic [N_FLOORS-1:0] w_req_mask;
    logic [N_FLOORS-1:0] w_clear;
    logic                w_reload;

    // Floor-indexed helpers written as loops so any FLOOR_W/N_FLOORS pairing indexes safely.
    function automatic logic bit_at(input logic [N_FLOORS-1:0] v, input logic [FLOOR_W-1:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < N_FLOORS; i++)
            if (FLOOR_W'(i) == f) r = v[i];
        return r;
    endfunction

    function automatic logic [N_FLOORS-1:0] onehot(input logic [FLOOR_W-1:0] f);
        logic [N_FLOORS-1:0] r;
        r = '0;
        for (int i = 0; i < N_FLOORS; i++)
            r[i] = (FLOOR_W'(i) == f);
        return r;
    endfunction

    function automatic logic any_above(input logic [N_FLOORS-1:0] v, input logic [FLOOR_W-1:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < N_FLOORS; i++)
            if (FLOOR_W'(i) > f) r = r | v[i];
        return r;
    endfunction

    function automatic logic any_below(input logic [N_FLOORS-1:0] v, input logic [FLOOR_W-1:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < N_FLOORS; i++)
            if (FLOOR_W'(i) < f) r = r | v[i];
        return r;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_floor   <= '0;
            r_pending <= '0;
            r_dir_up  <= 1'b1;
            r_timer   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_floor   <= w_floor_nxt;
            r_pending <= w_pending_nxt;
            r_dir_up  <= w_dir_up_nxt;
            r_timer   <= w_timer_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_floor_nxt  = r_floor;
        w_dir_up_nxt = r_dir_up;
        w_timer_nxt  = r_timer;
        w_clear      = '0;
        w_floor_up   = r_floor + 1'b1;
        w_floor_dn   = r_floor - 1'b1;

        // A press for the floor whose door is open extends the door instead of queueing.
        w_reload   = (r_state == DOOR_OPEN) && bit_at(bus.req, r_floor);
        w_req_mask = bus.req;
        if (r_state == DOOR_OPEN)
            w_req_mask = bus.req & ~onehot(r_floor);

        // Decisions look only at r_pending, so a request landing in a tick cycle waits a tick.
        if (bus.slowref) begin
            case (r_state)
                IDLE: begin
                    if (bit_at(r_pending, r_floor)) begin
                        w_state_nxt = DOOR_OPEN;
                        w_clear     = onehot(r_floor);
                        w_timer_nxt = TIMER_LOAD;
                    end else if (r_dir_up && any_above(r_pending, r_floor)) begin
                        w_state_nxt = MOVE_UP;
                    end else if (any_below(r_pending, r_floor)) begin
                        w_state_nxt  = MOVE_DOWN;
                        w_dir_up_nxt = 1'b0;
                    end else if (any_above(r_pending, r_floor)) begin
                        w_state_nxt  = MOVE_UP;
                        w_dir_up_nxt = 1'b1;
                    end
                end
                MOVE_UP: begin
                    w_floor_nxt = w_floor_up;
                    if (bit_at(r_pending, w_floor_up)) begin
                        w_state_nxt = DOOR_OPEN;
                        w_clear     = onehot(w_floor_up);
                        w_timer_nxt = TIMER_LOAD;
                    end else if (!any_above(r_pending, w_floor_up)) begin
                        w_state_nxt = IDLE;
                    end
                end
                MOVE_DOWN: begin
                    w_floor_nxt = w_floor_dn;
                    if (bit_at(r_pending, w_floor_dn)) begin
                        w_state_nxt = DOOR_OPEN;
                        w_clear     = onehot(w_floor_dn);
                        w_timer_nxt = TIMER_LOAD;
                    end else if (!any_below(r_pending, w_floor_dn)) begin
                        w_state_nxt = IDLE;
                    end
                end
                DOOR_OPEN: begin
                    if (r_timer == '0)
                        w_state_nxt = IDLE;
                    else
                        w_timer_nxt = r_timer - 1'b1;
                end
                default: w_state_nxt = IDLE;
            endcase
        end

        // Reload wins over a closing tick in the same cycle: the door stays open.
        if (w_reload) begin
            w_state_nxt = DOOR_OPEN;
            w_timer_nxt = TIMER_LOAD;
        end

        // Clear after set: a request for the floor being serviced this tick is consumed.
        w_pending_nxt = (r_pending | w_req_mask) & ~w_clear;
    end

    assign bus.floor       = r_floor;
    assign bus.pending     = r_pending;
    assign bus.door_open   = (r_state == DOOR_OPEN);
    assign bus.moving_up   = (r_state == MOVE_UP);
    assign bus.moving_down = (r_state == MOVE_DOWN);

    // Travel is only entered/continued with a request beyond the car, so the ends are never overrun.
    a_no_overrun: assert property (@(posedge clk) disable iff (reset)
        !(bus.slowref && ((r_state == MOVE_UP && r_floor == TOP_FLOOR) ||
                          (r_state == MOVE_DOWN && r_floor == '0))));
endmodule

// File: tb/tb_lift_ctrl.sv
// tb/tb_lift_ctrl.sv - self-checking bench for lift_ctrl
module tb_lift_ctrl;
    localparam int N = 4;
    localparam int W = 2;
    localparam int T = 3;

    localparam int M_IDLE = 0;
    localparam int M_UP   = 1;
    localparam int M_DOWN = 2;
    localparam int M_DOOR = 3;

    typedef struct {
        bit           s;
        logic [N-1:0] r;
        logic [W-1:0] f;
        bit           d;
        bit           u;
        bit           dn;
        logic [N-1:0] p;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    always #10 clk = ~clk;

    lift_ctrl_if #(.N_FLOORS(N), .FLOOR_W(W)) bus ();

    lift_ctrl #(.N_FLOORS(N), .FLOOR_W(W), .DOOR_TICKS(T)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Reference model: floor number, travel mode, request list and remaining door ticks.
    int m_floor;
    int m_mode;
    int m_left;
    bit m_dir_up;
    bit m_pend[N];

    function automatic bit any_range(int lo, int hi);
        bit r = 0;
        for (int i = lo; i <= hi; i++)
            if (i >= 0 && i < N && m_pend[i]) r = 1;
        return r;
    endfunction

    task automatic model_reset();
        m_floor = 0; m_mode = M_IDLE; m_left = 0; m_dir_up = 1;
        for (int i = 0; i < N; i++) m_pend[i] = 0;
    endtask

    task automatic model_step(input bit s, input logic [N-1:0] r);
        int  old_mode  = m_mode;
        int  old_floor = m_floor;
        int  serve     = -1;
        bit  reload    = (old_mode == M_DOOR) && r[old_floor];
        if (s) begin
            case (old_mode)
                M_IDLE: begin
                    if (m_pend[old_floor]) begin
                        serve = old_floor; m_mode = M_DOOR; m_left = T;
                    end else if (m_dir_up && any_range(old_floor + 1, N - 1)) begin
                        m_mode = M_UP;
                    end else if (any_range(0, old_floor - 1)) begin
                        m_mode = M_DOWN; m_dir_up = 0;
                    end else if (any_range(old_floor + 1, N - 1)) begin
                        m_mode = M_UP; m_dir_up = 1;
                    end
                end
                M_UP: begin
                    m_floor = old_floor + 1;
                    if (m_pend[m_floor]) begin
                        serve = m_floor; m_mode = M_DOOR; m_left = T;
                    end else if (!any_range(m_floor + 1, N - 1)) begin
                        m_mode = M_IDLE;
                    end
                end
                M_DOWN: begin
                    m_floor = old_floor - 1;
                    if (m_pend[m_floor]) begin
                        serve = m_floor; m_mode = M_DOOR; m_left = T;
                    end else if (!any_range(0, m_floor - 1)) begin
                        m_mode = M_IDLE;
                    end
                end
                default: begin
                    m_left = m_left - 1;
                    if (m_left == 0) m_mode = M_IDLE;
                end
            endcase
        end
        if (reload) begin
            m_mode = M_DOOR; m_left = T;
        end
        for (int i = 0; i < N; i++) begin
            if (r[i] && !(old_mode == M_DOOR && i == old_floor)) m_pend[i] = 1;
            if (i == serve) m_pend[i] = 0;
        end
    endtask

    function automatic logic [W+2+N:0] model_out();
        logic [N-1:0] p;
        for (int i = 0; i < N; i++) p[i] = m_pend[i];
        return {W'(m_floor), m_mode == M_DOOR, m_mode == M_UP, m_mode == M_DOWN, p};
    endfunction

    function automatic logic [W+2+N:0] dut_out();
        return {bus.floor, bus.door_open, bus.moving_up, bus.moving_down, bus.pending};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input bit s, input logic [N-1:0] r);
        @(negedge clk);
        bus.slowref = s;
        bus.req     = r;
        model_step(s, r);
        @(posedge clk);
        #1;
        bus.slowref = 1'b0;
        bus.req     = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.slowref = 1'b0;
        bus.req = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    vec_t tbl[$];
    int   bad;
    logic [N-1:0] exp_p;
    logic [N-1:0] rr;

    initial begin
        reset = 1'b1;
        bus.slowref = 1'b0;
        bus.req = '0;
        model_reset();

        //                s   req      f  d  u  dn pending
        tbl.push_back('{1'b0, 4'b0001, 2'd0, 1'b0, 1'b0, 1'b0, 4'b0001});
        tbl.push_back('{1'b1, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0, 4'b0000});
        tbl.push_back('{1'b1, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0, 4'b0000});
        tbl.push_back('{1'b1, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0, 4'b0000});
        tbl.push_back('{1'b1, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0, 4'b0000});
        tbl.push_back('{1'b0, 4'b1000, 2'd0, 1'b0, 1'b0, 1'b0, 4'b1000});
        tbl.push_back('{1'b1, 4'b0000, 2'd0, 1'b0, 1'b1, 1'b0, 4'b1000});
        tbl.push_back('{1'b1, 4'b0000, 2'd1, 1'b0, 1'b1, 1'b0, 4'b1000});
        tbl.push_back('{1'b1, 4'b0000, 2'd2, 1'b0, 1'b1, 1'b0, 4'b1000});
        tbl.push_back('{1'b1, 4'b0000, 2'd3, 1'b1, 1'b0, 1'b0, 4'b0000});
        tbl.push_back('{1'b1, 4'b0000, 2'd3, 1'b1, 1'b0, 1'b0, 4'b0000});
        tbl.push_back('{1'b1, 4'b0000, 2'd3, 1'b1, 1'b0, 1'b0, 4'b0000});
        tbl.push_back('{1'b1, 4'b0000, 2'd3, 1'b0, 1'b0, 1'b0, 4'b0000});
        tbl.push_back('{1'b1, 4'b0100, 2'd3, 1'b0, 1'b0, 1'b0, 4'b0100});
        tbl.push_back('{1'b0, 4'b0000, 2'd3, 1'b0, 1'b0, 1'b0, 4'b0100});
        tbl.push_back('{1'b1, 4'b0000, 2'd3, 1'b0, 1'b0, 1'b1, 4'b0100});
        tbl.push_back('{1'b1, 4'b0000, 2'd2, 1'b1, 1'b0, 1'b0, 4'b0000});
        tbl.push_back('{1'b1, 4'b0100, 2'd2, 1'b1, 1'b0, 1'b0, 4'b0000});
        tbl.push_back('{1'b1, 4'b0000, 2'd2, 1'b1, 1'b0, 1'b0, 4'b0000});
        tbl.push_back('{1'b1, 4'b0000, 2'd2, 1'b1, 1'b0, 1'b0, 4'b0000});
        tbl.push_back('{1'b1, 4'b0000, 2'd2, 1'b0, 1'b0, 1'b0, 4'b0000});
        tbl.push_back('{1'b0, 4'b0010, 2'd2, 1'b0, 1'b0, 1'b0, 4'b0010});
        tbl.push_back('{1'b1, 4'b0010, 2'd2, 1'b0, 1'b0, 1'b1, 4'b0010});
        tbl.push_back('{1'b1, 4'b0010, 2'd1, 1'b1, 1'b0, 1'b0, 4'b0000});

        do_reset();
        #1;
        chk("reset_state", 32'(dut_out()), 32'd0);

        foreach (tbl[i]) begin
            cyc(tbl[i].s, tbl[i].r);
            chk($sformatf("vec%0d", i), 32'(dut_out()),
                32'({tbl[i].f, tbl[i].d, tbl[i].u, tbl[i].dn, tbl[i].p}));
        end

        // Directional preference: heading up from floor 1 with requests at 3 and 0.
        do_reset();
        cyc(1'b0, 4'b1010);
        cyc(1'b1, 4'b0000);
        chk("scan_start_up", 32'(bus.moving_up), 32'd1);
        cyc(1'b1, 4'b0000);
        chk("scan_door_f1", 32'({bus.floor, bus.door_open}), 32'({2'd1, 1'b1}));
        cyc(1'b0, 4'b0001);
        chk("scan_pending", 32'(bus.pending), 32'b1001);
        repeat (3) cyc(1'b1, 4'b0000);
        cyc(1'b1, 4'b0000);
        chk("scan_pref_up", 32'({bus.moving_up, bus.moving_down}), 32'b10);
        repeat (2) cyc(1'b1, 4'b0000);
        chk("scan_door_f3", 32'({bus.floor, bus.door_open, bus.moving_up}), 32'({2'd3, 1'b1, 1'b0}));
        repeat (3) cyc(1'b1, 4'b0000);
        cyc(1'b1, 4'b0000);
        chk("scan_then_down", 32'(bus.moving_down), 32'd1);
        repeat (3) cyc(1'b1, 4'b0000);
        chk("scan_door_f0", 32'(dut_out()), 32'({2'd0, 1'b1, 1'b0, 1'b0, 4'b0000}));

        // Door reload at floor 2 with the timer already expired.
        do_reset();
        cyc(1'b0, 4'b0100);
        repeat (5) cyc(1'b1, 4'b0000);
        chk("reload_pre", 32'({bus.floor, bus.door_open}), 32'({2'd2, 1'b1}));
        cyc(1'b0, 4'b0100);
        chk("reload_no_latch", 32'({bus.door_open, bus.pending}), 32'({1'b1, 4'b0000}));
        repeat (2) cyc(1'b1, 4'b0000);
        chk("reload_still_open", 32'(bus.door_open), 32'd1);
        cyc(1'b1, 4'b0000);
        chk("reload_closed", 32'(bus.door_open), 32'd0);

        // Asynchronous reset while moving down from floor 2.
        cyc(1'b0, 4'b0001);
        cyc(1'b1, 4'b0000);
        chk("pre_reset_move", 32'(dut_out()), 32'({2'd2, 1'b0, 1'b0, 1'b1, 4'b0001}));
        @(negedge clk);
        #3 reset = 1'b1;
        #1;
        chk("reset_async", 32'(dut_out()), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (3) cyc(1'b1, 4'b0000);
        chk("reset_no_motion", 32'(dut_out()), 32'd0);

        // slowref held low: motion frozen, requests still captured.
        do_reset();
        cyc(1'b0, 4'b1000);
        cyc(1'b1, 4'b0000);
        exp_p = 4'b1000;
        bad = 0;
        for (int k = 0; k < 1000; k++) begin
            rr = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            cyc(1'b0, rr);
            exp_p = exp_p | rr;
            if (bus.floor !== 2'd0 || bus.moving_up !== 1'b1) bad++;
        end
        chk("hold_frozen", 32'(bad), 32'd0);
        chk("hold_pending", 32'(bus.pending), 32'(exp_p));
        cyc(1'b1, 4'b0000);
        chk("hold_resume", 32'(bus.floor), 32'd1);

        // Random traffic against the reference model.
        do_reset();
        for (int k = 0; k < 4000; k++) begin
            for (int b = 0; b < N; b++) rr[b] = ($urandom_range(0, 9) == 0);
            cyc($urandom_range(0, 2) == 0, rr);
            chk($sformatf("rand%0d", k), 32'(dut_out()), 32'(model_out()));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
